nem_ohmux_sel_seq: RTL and testbench

//  Drives the one-hot select lines S[N_IN-1:0] of a NEM-relay one-hot inverting mux (ZN = !(|(S & I))).

---
 rtl/nem_relay_pkg.sv | 23 ++
 rtl/nem_settle_timer.sv | 29 ++
 rtl/nem_ohmux_sel_seq.sv | 178 +++++++++++++++++
 tb/tb_nem_ohmux_sel_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nem_relay_pkg.sv
// Shared types for NEM-relay select sequencing: sequencer state encoding and
// a one-hot decode helper.
package nem_relay_pkg;

    localparam int OH_MAX   = 64;
    localparam int OH_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STABLE  = 2'd1,
        RELEASE = 2'd2,
        ENGAGE  = 2'd3
    } relay_state_e;

    // Callers truncate the result to their own select width.
    function automatic logic [OH_MAX-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
        logic [OH_MAX-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/nem_settle_timer.sv
// Loadable down-counter with a zero flag; parks at zero until reloaded.
module nem_settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/nem_ohmux_sel_seq.sv
// Break-before-make one-hot select sequencer for a NEM-relay mux.
// Define NEM_OHMUX_SEL_OFF_EN to add the off_req port (drive all selects low).
module nem_ohmux_sel_seq
    import nem_relay_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int T_RELEASE = 4,
    parameter int T_ENGAGE  = 6,
    localparam int SEL_W    = (N_IN > 2) ? $clog2(N_IN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef NEM_OHMUX_SEL_OFF_EN
    input  logic             off_req,
`endif
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_idx,
    output logic [N_IN-1:0]  sel,
    output logic [SEL_W-1:0] cur_idx,
    output logic             cur_vld,
    output logic             done,
    output logic             err
);

    localparam int T_MAX = (T_RELEASE > T_ENGAGE) ? T_RELEASE : T_ENGAGE;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;
    // The timer is loaded with T-1 so each phase lasts exactly T cycles.
    localparam logic [CNT_W-1:0] REL_LD = CNT_W'(T_RELEASE - 1);
    localparam logic [CNT_W-1:0] ENG_LD = CNT_W'(T_ENGAGE - 1);

    relay_state_e     state_q, state_d;
    logic [N_IN-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0] cur_idx_q, cur_idx_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic             cur_vld_q, cur_vld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ld_en;
    logic [CNT_W-1:0] ld_val;
    logic             cnt_zero;
    logic             idx_bad;
`ifdef NEM_OHMUX_SEL_OFF_EN
    logic             off_pend_q, off_pend_d;
`endif

    assign req_ready = (state_q == IDLE) || (state_q == STABLE);
    assign idx_bad   = 32'(req_idx) >= 32'(N_IN);

    nem_settle_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld_en),
        .load_val (ld_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cur_idx_d = cur_idx_q;
        cur_vld_d = cur_vld_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ld_en     = 1'b0;
        ld_val    = '0;
`ifdef NEM_OHMUX_SEL_OFF_EN
        off_pend_d = off_pend_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef NEM_OHMUX_SEL_OFF_EN
                if (off_req)
                    done_d = 1'b1;
                else
`endif
                if (req_valid) begin
                    if (idx_bad) begin
                        err_d = 1'b1;
                    end else begin
                        // Nothing to release: engage the new relay straight away.
                        tgt_d   = req_idx;
                        sel_d   = N_IN'(onehot(OH_IDX_W'(req_idx)));
                        state_d = ENGAGE;
                        ld_en   = 1'b1;
                        ld_val  = ENG_LD;
                    end
                end
            end
            STABLE: begin
`ifdef NEM_OHMUX_SEL_OFF_EN
                if (off_req) begin
                    sel_d      = '0;
                    cur_vld_d  = 1'b0;
                    off_pend_d = 1'b1;
                    state_d    = RELEASE;
                    ld_en      = 1'b1;
                    ld_val     = REL_LD;
                end else
`endif
                if (req_valid) begin
                    if (idx_bad) begin
                        err_d = 1'b1;
                    end else if (req_idx == cur_idx_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d     = req_idx;
                        sel_d     = '0;
                        cur_vld_d = 1'b0;
                        state_d   = RELEASE;
                        ld_en     = 1'b1;
                        ld_val    = REL_LD;
                    end
                end
            end
            RELEASE: begin
                if (cnt_zero) begin
`ifdef NEM_OHMUX_SEL_OFF_EN
                    if (off_pend_q) begin
                        off_pend_d = 1'b0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                    end else
`endif
                    begin
                        sel_d   = N_IN'(onehot(OH_IDX_W'(tgt_q)));
                        state_d = ENGAGE;
                        ld_en   = 1'b1;
                        ld_val  = ENG_LD;
                    end
                end
            end
            ENGAGE: begin
                if (cnt_zero) begin
                    state_d   = STABLE;
                    cur_idx_d = tgt_q;
                    cur_vld_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cur_idx_q <= '0;
            tgt_q     <= '0;
            cur_vld_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef NEM_OHMUX_SEL_OFF_EN
            off_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cur_idx_q <= cur_idx_d;
            tgt_q     <= tgt_d;
            cur_vld_q <= cur_vld_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef NEM_OHMUX_SEL_OFF_EN
            off_pend_q <= off_pend_d;
`endif
        end
    end

    assign sel     = sel_q;
    assign cur_idx = cur_idx_q;
    assign cur_vld = cur_vld_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// Directed bench for nem_ohmux_sel_seq: a 2-input instance for sequencing and
// a 3-input instance for the out-of-range index path.
module tb_nem_ohmux_sel_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_valid = 1'b0, a_ready;
    logic [0:0] a_idx = '0, a_cur_idx;
    logic [1:0] a_sel;
    logic       a_cur_vld, a_done, a_err;
`ifdef NEM_OHMUX_SEL_OFF_EN
    logic       a_off = 1'b0;
`endif

    logic       b_valid = 1'b0, b_ready;
    logic [1:0] b_idx = '0, b_cur_idx;
    logic [2:0] b_sel;
    logic       b_cur_vld, b_done, b_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    nem_ohmux_sel_seq #(.N_IN(2), .T_RELEASE(4), .T_ENGAGE(6)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef NEM_OHMUX_SEL_OFF_EN
        .off_req   (a_off),
`endif
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_idx   (a_idx),
        .sel       (a_sel),
        .cur_idx   (a_cur_idx),
        .cur_vld   (a_cur_vld),
        .done      (a_done),
        .err       (a_err)
    );

    nem_ohmux_sel_seq #(.N_IN(3), .T_RELEASE(4), .T_ENGAGE(6)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef NEM_OHMUX_SEL_OFF_EN
        .off_req   (1'b0),
`endif
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_idx   (b_idx),
        .sel       (b_sel),
        .cur_idx   (b_cur_idx),
        .cur_vld   (b_cur_vld),
        .done      (b_done),
        .err       (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds valid for one edge; returns just after the accept edge (first cycle after accept).
    task automatic req_a(input logic [0:0] idx);
        a_valid = 1'b1;
        a_idx   = idx;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic req_b(input logic [1:0] idx);
        b_valid = 1'b1;
        b_idx   = idx;
        tick();
        b_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_sel",     32'(a_sel),     32'h0);
        chk("rst_cur_idx", 32'(a_cur_idx), 32'h0);
        chk("rst_cur_vld", 32'(a_cur_vld), 32'h0);
        chk("rst_done",    32'(a_done),    32'h0);
        chk("rst_err",     32'(a_err),     32'h0);
        chk("rst_ready",   32'(a_ready),   32'h1);

        // IDLE -> idx1: engage next cycle, settled 7 cycles after accept
        req_a(1'b1);
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("t1_sel_k%0d", k),  32'(a_sel),     32'h2);
            chk($sformatf("t1_done_k%0d", k), 32'(a_done),    32'(k == 7));
            chk($sformatf("t1_vld_k%0d", k),  32'(a_cur_vld), 32'(k == 7));
            if (k == 2) chk("t1_ready_busy", 32'(a_ready), 32'h0);
            if (k < 7) tick();
        end
        chk("t1_cur_idx", 32'(a_cur_idx), 32'h1);

        // STABLE idx1 -> idx0: 4 cycles of no path, then 01; done at 11
        req_a(1'b0);
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("t2_sel_k%0d", k),  32'(a_sel),  (k <= 4) ? 32'h0 : 32'h1);
            chk($sformatf("t2_done_k%0d", k), 32'(a_done), 32'(k == 11));
            if (k < 11) tick();
        end
        chk("t2_cur_idx", 32'(a_cur_idx), 32'h0);
        chk("t2_cur_vld", 32'(a_cur_vld), 32'h1);

        // Same index: done immediately, no toggle
        req_a(1'b0);
        chk("t3_done", 32'(a_done), 32'h1);
        chk("t3_sel",  32'(a_sel),  32'h1);
        tick();
        chk("t3_done_pulse", 32'(a_done), 32'h0);
        chk("t3_sel_hold",   32'(a_sel),  32'h1);

        // N_IN=3: settle on idx2 (top legal index), then reject idx3
        req_b(2'd2);
        for (int k = 1; k < 7; k++) tick();
        chk("t4_done_idx2", 32'(b_done), 32'h1);
        chk("t4_sel_idx2",  32'(b_sel),  32'h4);
        req_b(2'd3);
        chk("t4_err",     32'(b_err),     32'h1);
        chk("t4_no_done", 32'(b_done),    32'h0);
        chk("t4_sel",     32'(b_sel),     32'h4);
        chk("t4_cur_idx", 32'(b_cur_idx), 32'h2);
        chk("t4_cur_vld", 32'(b_cur_vld), 32'h1);
        chk("t4_ready",   32'(b_ready),   32'h1);
        tick();
        chk("t4_err_pulse", 32'(b_err), 32'h0);

        // Reset during ENGAGE clears sel without a clock edge
        req_a(1'b1);
        for (int k = 1; k < 6; k++) tick();
        chk("t5_sel_engage", 32'(a_sel), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_sel_async", 32'(a_sel),     32'h0);
        chk("t5_vld_async", 32'(a_cur_vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_ready", 32'(a_ready), 32'h1);
        chk("t5_sel",   32'(a_sel),   32'h0);

`ifdef NEM_OHMUX_SEL_OFF_EN
        req_a(1'b1);
        for (int k = 1; k < 7; k++) tick();
        chk("t6_stable", 32'(a_cur_vld), 32'h1);
        // off_req and req_valid together: off wins
        a_off   = 1'b1;
        a_valid = 1'b1;
        a_idx   = 1'b0;
        tick();
        a_off   = 1'b0;
        a_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("t6_sel_k%0d", k),   32'(a_sel),     32'h0);
            chk($sformatf("t6_done_k%0d", k),  32'(a_done),    32'(k == 5));
            chk($sformatf("t6_vld_k%0d", k),   32'(a_cur_vld), 32'h0);
            chk($sformatf("t6_ready_k%0d", k), 32'(a_ready),   32'(k == 5));
            if (k < 5) tick();
        end
        // off in IDLE completes next cycle
        a_off = 1'b1;
        tick();
        a_off = 1'b0;
        chk("t6_idle_done", 32'(a_done), 32'h1);
        chk("t6_idle_sel",  32'(a_sel),  32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
